// File: rtl/rpn_pkg.sv
// Shared opcode, FSM-state and error-bit definitions for the RPN sequencer.
// Build option: define RPN_MUL_EN to make opcode 111 a legal MUL.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_LIT  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_DROP = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_L = 3'd1,
    ST_POP_B  = 3'd2,
    ST_POP_A  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_PUSH_R = 3'd5,
    ST_DROP   = 3'd6
  } state_e;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UDF  = 1;
  localparam int ERR_ILL  = 2;
  localparam int ERR_BITS = 3;

  // True for opcodes that pop two operands and push one result.
  function automatic logic is_binary(input op_e op);
    logic bin;
    bin = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
          (op == OP_OR)  || (op == OP_XOR);
`ifdef RPN_MUL_EN
    bin = bin || (op == OP_MUL);
`endif
    return bin;
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU for the RPN sequencer (A op B, wrapping).
// Build option: RPN_MUL_EN adds the truncated multiplier for OP_MUL.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`ifdef RPN_MUL_EN
      OP_MUL: result = a * b;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Reverse-Polish token sequencer driving an external LIFO stack; tracks
// occupancy itself and raises sticky overflow/underflow/illegal flags.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       TOK_VALID,
  output logic                       TOK_READY,
  input  logic [2:0]                 TOK_OP,
  input  logic [DATA_WIDTH-1:0]      TOK_DATA,
  output logic                       STK_PUSH,
  output logic                       STK_POP,
  output logic [DATA_WIDTH-1:0]      STK_WDATA,
  input  logic [DATA_WIDTH-1:0]      STK_RDATA,
  output logic                       RES_VALID,
  output logic [DATA_WIDTH-1:0]      RES_DATA,
  output logic [$clog2(DEPTH):0]     DEPTH_O,
  output logic                       ERR_OVERFLOW,
  output logic                       ERR_UNDERFLOW,
  output logic                       ERR_ILLEGAL,
  input  logic                       ERR_CLR
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] TWO       = DW'(2);

  state_e                state_reg, state_next;
  op_e                   op_reg;
  op_e                   tok_op;
  logic [DATA_WIDTH-1:0] lit_reg, b_reg, result_reg, alu_result;
  logic [DW-1:0]         depth_reg;
  logic [ERR_BITS-1:0]   err_reg, err_set;
  logic                  accept;

  assign tok_op = op_e'(TOK_OP);
  assign accept = TOK_VALID && (state_reg == ST_IDLE);

  rpn_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op_reg),
    .a      (STK_RDATA),
    .b      (b_reg),
    .result (alu_result)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Rejected tokens are consumed in IDLE and only raise a flag.
  always_comb begin
    state_next = state_reg;
    err_set    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (TOK_VALID) begin
          if (tok_op == OP_LIT) begin
            if (depth_reg < DEPTH_MAX) state_next = ST_PUSH_L;
            else                       err_set[ERR_OVF] = 1'b1;
          end else if (tok_op == OP_DROP) begin
            if (depth_reg != '0) state_next = ST_DROP;
            else                 err_set[ERR_UDF] = 1'b1;
          end else if (is_binary(tok_op)) begin
            if (depth_reg >= TWO) state_next = ST_POP_B;
            else                  err_set[ERR_UDF] = 1'b1;
          end else begin
            err_set[ERR_ILL] = 1'b1;
          end
        end
      end
      ST_PUSH_L: state_next = ST_IDLE;
      ST_POP_B:  state_next = ST_POP_A;
      ST_POP_A:  state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_PUSH_R;
      ST_PUSH_R: state_next = ST_IDLE;
      ST_DROP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Stack read data lags a pop by one cycle: B is on STK_RDATA in POP_A, A in EXEC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_reg     <= OP_LIT;
      lit_reg    <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      depth_reg  <= '0;
      err_reg    <= '0;
    end else begin
      if (accept) begin
        op_reg  <= tok_op;
        lit_reg <= TOK_DATA;
      end
      if (state_reg == ST_POP_A) b_reg <= STK_RDATA;
      if (state_reg == ST_EXEC)  result_reg <= alu_result;
      case (state_reg)
        ST_PUSH_L, ST_PUSH_R:        depth_reg <= depth_reg + 1'b1;
        ST_POP_B, ST_POP_A, ST_DROP: depth_reg <= depth_reg - 1'b1;
        default:                     depth_reg <= depth_reg;
      endcase
      err_reg <= (ERR_CLR ? '0 : err_reg) | err_set;
    end
  end

  always_comb begin
    TOK_READY = (state_reg == ST_IDLE);
    STK_PUSH  = (state_reg == ST_PUSH_L) || (state_reg == ST_PUSH_R);
    STK_POP   = (state_reg == ST_POP_B) || (state_reg == ST_POP_A) ||
                (state_reg == ST_DROP);
    RES_VALID = (state_reg == ST_PUSH_R);
    STK_WDATA = '0;
    if (state_reg == ST_PUSH_L)      STK_WDATA = lit_reg;
    else if (state_reg == ST_PUSH_R) STK_WDATA = result_reg;
  end

  assign RES_DATA      = result_reg;
  assign DEPTH_O       = depth_reg;
  assign ERR_OVERFLOW  = err_reg[ERR_OVF];
  assign ERR_UNDERFLOW = err_reg[ERR_UDF];
  assign ERR_ILLEGAL   = err_reg[ERR_ILL];

endmodule

// File: tb/tb_rpn_sequencer.sv
// Randomized bench for rpn_sequencer with a behavioural LIFO attached and a
// queue-based RPN reference model.
module tb_rpn_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tok_valid, tok_ready;
  logic [2:0]    tok_op;
  logic [DW-1:0] tok_data;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata, stk_rdata;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [2:0]    depth_o;
  logic          err_ovf, err_udf, err_ill, err_clr;

  always #5 clk = ~clk;

  rpn_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .TOK_VALID(tok_valid), .TOK_READY(tok_ready), .TOK_OP(tok_op), .TOK_DATA(tok_data),
    .STK_PUSH(stk_push), .STK_POP(stk_pop), .STK_WDATA(stk_wdata), .STK_RDATA(stk_rdata),
    .RES_VALID(res_valid), .RES_DATA(res_data), .DEPTH_O(depth_o),
    .ERR_OVERFLOW(err_ovf), .ERR_UNDERFLOW(err_udf), .ERR_ILLEGAL(err_ill),
    .ERR_CLR(err_clr)
  );

  // Behavioural stack: active-low reset tied to ~RST, read data registered on POP.
  logic          stk_rst_n;
  logic [DW-1:0] smem [DEPTH];
  int            sp;
  assign stk_rst_n = ~rst;
  always @(posedge clk) begin
    if (!stk_rst_n) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else if (stk_push && sp < DEPTH) begin
      smem[sp] <= stk_wdata;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_rdata <= smem[sp-1];
      sp        <= sp - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int unsigned   mstack[$];
  logic [2:0]    merr;   // {illegal, underflow, overflow}
  logic [DW-1:0] mlast;
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  function automatic int unsigned ref_calc(input logic [2:0] op, input int unsigned a, input int unsigned b);
    case (op)
      3'd1:    return (a + b) % 256;
      3'd2:    return (a + 256 - b) % 256;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd7:    return (a * b) % 256;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tok_valid = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mstack.delete(); merr = '0; mlast = '0;
    check("rst_ready", tok_ready, 1);
    check("rst_push_pop", {stk_push, stk_pop}, 0);
    check("rst_res", {res_valid, res_data}, 0);
    check("rst_depth", depth_o, 0);
    check("rst_err", {err_ill, err_udf, err_ovf}, 0);
    rst = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    merr = '0;
    check("errclr", {err_ill, err_udf, err_ovf}, 0);
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] data, input bit clr);
    int exp_push = 0, exp_pop = 0, exp_res_cyc = 0, exp_ready = 2;
    int push_cnt = 0, pop_cnt = 0, res_cnt = 0, res_cyc = 0, ready_cyc = 0;
    logic [DW-1:0] res_seen = '0;
    logic [2:0] new_err = '0;
    bit both = 1'b0, done = 1'b0;
    bit is_bin = (op >= 3'd1 && op <= 3'd5) || (op == 3'd7 && MUL_EN);
    int unsigned a, b;

    if (op == 3'd0) begin
      if (mstack.size() == DEPTH) new_err[0] = 1'b1;
      else begin mstack.push_back(data); exp_push = 1; end
    end else if (op == 3'd6) begin
      if (mstack.size() == 0) new_err[1] = 1'b1;
      else begin void'(mstack.pop_back()); exp_pop = 1; end
    end else if (is_bin) begin
      if (mstack.size() < 2) new_err[1] = 1'b1;
      else begin
        b = mstack.pop_back();
        a = mstack.pop_back();
        mlast = DW'(ref_calc(op, a, b));
        mstack.push_back(mlast);
        exp_push = 1; exp_pop = 2; exp_res_cyc = 4; exp_ready = 5;
      end
    end else begin
      new_err[2] = 1'b1;
    end
    if (new_err != '0) exp_ready = 1;
    merr = (clr ? 3'b000 : merr) | new_err;

    @(negedge clk);
    check("ready_pre", tok_ready, 1);
    tok_valid = 1'b1; tok_op = op; tok_data = data; err_clr = clr;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0; err_clr = 1'b0;
    for (int k = 1; k <= 10 && !done; k++) begin
      if (stk_push) push_cnt++;
      if (stk_pop) pop_cnt++;
      if (stk_push && stk_pop) both = 1'b1;
      if (res_valid) begin res_cnt++; res_cyc = k; res_seen = res_data; end
      if (tok_ready) begin ready_cyc = k; done = 1'b1; end
      else begin @(posedge clk); @(negedge clk); end
    end
    if (!done) check("ready_timeout", 0, 1);

    check("ready_cycle", ready_cyc, exp_ready);
    check("push_count", push_cnt, exp_push);
    check("pop_count", pop_cnt, exp_pop);
    check("push_pop_excl", both, 0);
    check("res_pulses", res_cnt, exp_res_cyc != 0 ? 1 : 0);
    if (exp_res_cyc != 0) begin
      check("res_cycle", res_cyc, exp_res_cyc);
      check("res_pulse_data", res_seen, mlast);
    end
    check("res_data_hold", res_data, mlast);
    check("depth", depth_o, mstack.size());
    check("errors", {err_ill, err_udf, err_ovf}, merr);
    $display("tok op=%0d data=%02h clr=%0d -> depth=%0d res=%02h err=%03b",
             op, data, clr, depth_o, res_data, {err_ill, err_udf, err_ovf});
  endtask

  initial begin
    int pulses;
    rst = 1'b1; tok_valid = 1'b0; tok_op = '0; tok_data = '0; err_clr = 1'b0;
    do_reset();

    send(3'd0, 8'h05, 0); send(3'd0, 8'h03, 0); send(3'd2, 8'h00, 0);   // 5-3 = 02
    send(3'd6, 8'h00, 0);
    send(3'd0, 8'h03, 0); send(3'd0, 8'h05, 0); send(3'd2, 8'h00, 0);   // 3-5 = FE
    send(3'd6, 8'h00, 0);
    send(3'd0, 8'hFF, 0); send(3'd0, 8'h02, 0); send(3'd1, 8'h00, 0);   // FF+02 = 01
    send(3'd6, 8'h00, 0);

    for (int i = 0; i < 5; i++) send(3'd0, 8'(i + 1), 0);              // 5th overflows
    clear_errors();
    for (int i = 0; i < 4; i++) send(3'd6, 8'h00, 0);
    send(3'd6, 8'h00, 0);                                               // underflow
    clear_errors();
    send(3'd0, 8'h09, 0); send(3'd1, 8'h00, 0);                         // ADD underflow
    send(3'd6, 8'h00, 0);
    for (int i = 0; i < 4; i++) send(3'd0, 8'h11, 0);
    send(3'd0, 8'h22, 1);                                               // new error beats ERR_CLR

    do_reset();
    send(3'd0, 8'h06, 0); send(3'd0, 8'h07, 0); send(3'd7, 8'h00, 0);   // MUL or illegal

    // Reset during POP_A of a legal ADD abandons the operation.
    do_reset();
    send(3'd0, 8'h01, 0); send(3'd0, 8'h02, 0);
    @(negedge clk);
    tok_valid = 1'b1; tok_op = 3'd1;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mstack.delete(); merr = '0; mlast = '0;
    check("midrst_ready", tok_ready, 1);
    check("midrst_depth", depth_o, 0);
    check("midrst_outs", {res_valid, stk_push, stk_pop}, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (res_valid || stk_push || stk_pop) pulses++;
      @(posedge clk); @(negedge clk);
    end
    check("midrst_quiet", pulses, 0);
    check("midrst_res_data", res_data, 0);
    $display("mid-op reset -> depth=%0d ready=%0d", depth_o, tok_ready);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      send(r < 3 ? 3'd0 : 3'(r - 2), 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
